// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory requesters (F, D), the shared memory port and the arbiter.
// The arbiter connects through the slave modport; requesters and memory connect through master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              f_req;
    logic              f_we;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_wdata;
    logic              f_ack;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_out;
    logic              busy;

    modport slave (
        input  f_req, f_we, f_addr, f_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_out,
        output f_ack, f_rdata, d_ack, d_rdata,
        output mem_address, mem_writeData, mem_read, mem_write, busy
    );

    modport master (
        output f_req, f_we, f_addr, f_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output mem_out,
        input  f_ack, f_rdata, d_ack, d_rdata,
        input  mem_address, mem_writeData, mem_read, mem_write, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory between fetch (F) and data (D).
// Each transaction: grant in IDLE/RESP, one strobe in ISSUE, one-cycle ack with read data in RESP.
module mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic ID_F = 1'b0;
    localparam logic ID_D = 1'b1;

    state_t            state_reg;
    logic              last_grant_reg;
    logic              id_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              read_reg;
    logic              write_reg;
    logic              busy_reg;
    logic [1:0]        ack_reg;

    // Requester inputs gathered into arrays indexed by requester id (0 = F, 1 = D).
    logic [1:0]        req;
    logic [1:0]        we_in;
    logic [ADDR_W-1:0] addr_in  [2];
    logic [DATA_W-1:0] wdata_in [2];

    assign req      = {bus.d_req, bus.f_req};
    assign we_in    = {bus.d_we,  bus.f_we};
    assign addr_in  = '{bus.f_addr,  bus.d_addr};
    assign wdata_in = '{bus.f_wdata, bus.d_wdata};

    logic grant_valid_next;
    logic grant_id_next;

    // In RESP only the requester that was not just served may be granted.
    always_comb begin
        grant_valid_next = 1'b0;
        grant_id_next    = ID_F;
        case (state_reg)
            IDLE: begin
                if (req[0] && req[1]) begin
                    grant_valid_next = 1'b1;
                    grant_id_next    = ~last_grant_reg;
                end else if (req[0]) begin
                    grant_valid_next = 1'b1;
                    grant_id_next    = ID_F;
                end else if (req[1]) begin
                    grant_valid_next = 1'b1;
                    grant_id_next    = ID_D;
                end
            end
            RESP: begin
                if (req[~id_reg]) begin
                    grant_valid_next = 1'b1;
                    grant_id_next    = ~id_reg;
                end
            end
            default: begin
                grant_valid_next = 1'b0;
                grant_id_next    = ID_F;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= ID_D;
            id_reg         <= ID_F;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            ack_reg        <= '0;
        end else begin
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
            ack_reg   <= '0;
            case (state_reg)
                IDLE, RESP: begin
                    if (grant_valid_next) begin
                        id_reg         <= grant_id_next;
                        we_reg         <= we_in[grant_id_next];
                        addr_reg       <= addr_in[grant_id_next];
                        wdata_reg      <= wdata_in[grant_id_next];
                        last_grant_reg <= grant_id_next;
                        read_reg       <= ~we_in[grant_id_next];
                        write_reg      <= we_in[grant_id_next];
                        busy_reg       <= 1'b1;
                        state_reg      <= ISSUE;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                ISSUE: begin
                    ack_reg[id_reg] <= 1'b1;
                    busy_reg        <= 1'b1;
                    state_reg       <= RESP;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Strobes and acks are masked during the reset cycle itself, not only after the edge.
    logic [1:0]        ack_out;
    logic [DATA_W-1:0] rdata [2];

    assign ack_out = ack_reg & {2{~rst}};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign rdata[gi] = (ack_out[gi] && !we_reg) ? bus.mem_out : '0;
        end
    endgenerate

    assign bus.f_ack         = ack_out[0];
    assign bus.d_ack         = ack_out[1];
    assign bus.f_rdata       = rdata[0];
    assign bus.d_rdata       = rdata[1];
    assign bus.mem_address   = addr_reg;
    assign bus.mem_writeData = wdata_reg;
    assign bus.mem_read      = read_reg & ~rst;
    assign bus.mem_write     = write_reg & ~rst;
    assign bus.busy          = busy_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all checked each
// cycle against a transaction-level model of grant order, strobe/ack timing and memory contents.
module tb_mem_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] init_val(int i);
        return (i == 3) ? 8'hC7 : 8'(i * 29 + 91);
    endfunction

    // Memory with registered read data, as the CPU's RAM behaves.
    logic          mem_init;
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
            bus.mem_out <= '0;
        end else begin
            if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writeData;
            if (bus.mem_read)  bus.mem_out <= mem[bus.mem_address];
        end
    end

    // Reference model: one transaction in flight, granted at cycle t_g.
    logic [DW-1:0] ref_mem [32];
    bit            t_valid;
    bit            t_id;
    bit            t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    int            t_g;
    bit            m_last;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int            f_ack_cyc, d_ack_cyc, ack_count, d_ack_n, wr_strobes, rd_strobes;
    logic [DW-1:0] last_f_rdata, last_d_rdata;
    int            f_renew, d_renew;
    bit            rand_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic new_fields(output logic we, output logic [AW-1:0] a, output logic [DW-1:0] wd);
        we = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        wd = 8'($urandom);
    endtask

    // Check the current cycle at the falling edge, advance the model, then drive the next cycle.
    task automatic tick();
        bit            e_strobe, e_ack, e_rd, e_wr, e_fa, e_da, fr, dr, nid, fa_seen, da_seen;
        logic [DW-1:0] e_rdata;
        @(negedge clk);
        e_strobe = t_valid && (cyc == t_g + 1);
        e_ack    = t_valid && (cyc == t_g + 2);
        e_rd     = !rst && e_strobe && !t_we;
        e_wr     = !rst && e_strobe && t_we;
        e_fa     = !rst && e_ack && (t_id == 1'b0);
        e_da     = !rst && e_ack && (t_id == 1'b1);
        e_rdata  = (e_ack && !t_we) ? ref_mem[t_addr] : '0;
        chk("mem_read",  32'(bus.mem_read),  32'(e_rd));
        chk("mem_write", 32'(bus.mem_write), 32'(e_wr));
        chk("f_ack",     32'(bus.f_ack),     32'(e_fa));
        chk("d_ack",     32'(bus.d_ack),     32'(e_da));
        chk("f_rdata",   32'(bus.f_rdata),   e_fa ? 32'(e_rdata) : 32'd0);
        chk("d_rdata",   32'(bus.d_rdata),   e_da ? 32'(e_rdata) : 32'd0);
        if (!rst) chk("busy", 32'(bus.busy), 32'(t_valid));
        if (!rst && e_strobe) begin
            chk("mem_address",   32'(bus.mem_address),   32'(t_addr));
            chk("mem_writeData", 32'(bus.mem_writeData), 32'(t_wdata));
        end

        fa_seen = bus.f_ack;
        da_seen = bus.d_ack;
        if (bus.mem_write) wr_strobes++;
        if (bus.mem_read)  rd_strobes++;
        if (fa_seen) begin f_ack_cyc = cyc; last_f_rdata = bus.f_rdata; ack_count++; end
        if (da_seen) begin d_ack_cyc = cyc; last_d_rdata = bus.d_rdata; ack_count++; d_ack_n++; end

        if (rst) begin
            t_valid = 1'b0;
            m_last  = 1'b1;
        end else begin
            if (e_strobe && t_we) ref_mem[t_addr] = t_wdata;
            if (!t_valid || e_ack) begin
                fr = bus.f_req;
                dr = bus.d_req;
                if (t_valid) begin
                    if (t_id == 1'b0) fr = 1'b0;
                    else              dr = 1'b0;
                end
                if (fr || dr) begin
                    nid     = (fr && dr) ? !m_last : dr;
                    t_id    = nid;
                    t_we    = nid ? bus.d_we    : bus.f_we;
                    t_addr  = nid ? bus.d_addr  : bus.f_addr;
                    t_wdata = nid ? bus.d_wdata : bus.f_wdata;
                    t_g     = cyc;
                    m_last  = nid;
                    t_valid = 1'b1;
                end else begin
                    t_valid = 1'b0;
                end
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        if (rand_mode) rst = ($urandom_range(0, 199) == 0);
        if (fa_seen) begin
            if (f_renew > 0 || (rand_mode && $urandom_range(0, 1) == 1)) begin
                if (f_renew > 0) f_renew--;
                new_fields(bus.f_we, bus.f_addr, bus.f_wdata);
            end else bus.f_req = 1'b0;
        end else if (rand_mode) begin
            if (bus.f_req && t_valid && t_id == 1'b0) new_fields(bus.f_we, bus.f_addr, bus.f_wdata);
            else if (!bus.f_req && $urandom_range(0, 2) == 0) begin
                bus.f_req = 1'b1;
                new_fields(bus.f_we, bus.f_addr, bus.f_wdata);
            end
        end
        if (da_seen) begin
            if (d_renew > 0 || (rand_mode && $urandom_range(0, 1) == 1)) begin
                if (d_renew > 0) d_renew--;
                new_fields(bus.d_we, bus.d_addr, bus.d_wdata);
            end else bus.d_req = 1'b0;
        end else if (rand_mode) begin
            if (bus.d_req && t_valid && t_id == 1'b1) new_fields(bus.d_we, bus.d_addr, bus.d_wdata);
            else if (!bus.d_req && $urandom_range(0, 2) == 0) begin
                bus.d_req = 1'b1;
                new_fields(bus.d_we, bus.d_addr, bus.d_wdata);
            end
        end
    endtask

    task automatic run_until_idle(input int limit);
        int k = 0;
        do begin
            tick();
            k++;
        end while ((t_valid || bus.f_req || bus.d_req) && k < limit);
        chk("idle_within_budget", 32'(k < limit), 32'd1);
    endtask

    int            s, w0, r0, a0, dn0;
    logic [DW-1:0] old5;

    initial begin
        rst = 1'b1;
        mem_init = 1'b1;
        bus.f_req = 0; bus.f_we = 0; bus.f_addr = '0; bus.f_wdata = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        f_renew = 0; d_renew = 0; rand_mode = 0;
        t_valid = 0; t_id = 0; t_we = 0; t_addr = '0; t_wdata = '0; t_g = 0; m_last = 1'b1;
        f_ack_cyc = 0; d_ack_cyc = 0; ack_count = 0; d_ack_n = 0; wr_strobes = 0; rd_strobes = 0;
        last_f_rdata = '0; last_d_rdata = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        @(posedge clk);
        #1;
        tick();
        tick();
        mem_init = 1'b0;
        rst = 1'b0;
        chk("reset_mem_address",   32'(bus.mem_address),   32'd0);
        chk("reset_mem_writeData", 32'(bus.mem_writeData), 32'd0);
        chk("reset_busy",          32'(bus.busy),          32'd0);

        // Simultaneous requests straight after reset: F wins, D follows via RESP->ISSUE.
        bus.f_req = 1; bus.f_we = 0; bus.f_addr = 5'd3; bus.f_wdata = 8'h11;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 5'd7; bus.d_wdata = 8'h5A;
        s = cyc;
        run_until_idle(30);
        chk("tie_f_ack_latency", 32'(f_ack_cyc - s), 32'd2);
        chk("tie_d_ack_latency", 32'(d_ack_cyc - s), 32'd4);
        chk("tie_f_rdata",       32'(last_f_rdata),  32'hC7);

        // F read of addr 3 with the address changing to 9 after the grant.
        dn0 = d_ack_n;
        bus.f_req = 1; bus.f_we = 0; bus.f_addr = 5'd3; bus.f_wdata = 8'h00;
        s = cyc;
        tick();
        bus.f_addr = 5'd9;
        tick();
        run_until_idle(30);
        chk("fread_ack_latency", 32'(f_ack_cyc - s), 32'd2);
        chk("fread_rdata",       32'(last_f_rdata),  32'hC7);
        chk("fread_no_d_ack",    32'(d_ack_n - dn0), 32'd0);

        // D write 31 <= BB, then read it back.
        w0 = wr_strobes; r0 = rd_strobes;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 5'd31; bus.d_wdata = 8'hBB;
        run_until_idle(30);
        chk("dwrite_write_strobes", 32'(wr_strobes - w0), 32'd1);
        chk("dwrite_read_strobes",  32'(rd_strobes - r0), 32'd0);
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 5'd31; bus.d_wdata = 8'h00;
        run_until_idle(30);
        chk("dread_rdata_31", 32'(last_d_rdata), 32'hBB);

        // Both sides held for 8 transactions: an ack every 2 cycles.
        f_renew = 3; d_renew = 3;
        bus.f_req = 1; new_fields(bus.f_we, bus.f_addr, bus.f_wdata);
        bus.d_req = 1; new_fields(bus.d_we, bus.d_addr, bus.d_wdata);
        s = cyc; a0 = ack_count;
        repeat (17) tick();
        chk("alt_ack_count", 32'(ack_count - a0), 32'd8);
        chk("alt_last_ack",  32'((f_ack_cyc > d_ack_cyc ? f_ack_cyc : d_ack_cyc) - s), 32'd16);
        run_until_idle(30);

        // Reset during the ISSUE cycle of a write to addr 5.
        old5 = ref_mem[5];
        w0 = wr_strobes; dn0 = d_ack_n;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 5'd5; bus.d_wdata = ~old5;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.d_req = 0;
        chk("rst_issue_busy",   32'(bus.busy),        32'd0);
        chk("rst_issue_addr",   32'(bus.mem_address), 32'd0);
        tick();
        tick();
        chk("rst_issue_no_write", 32'(wr_strobes - w0), 32'd0);
        chk("rst_issue_no_ack",   32'(d_ack_n - dn0),   32'd0);
        chk("rst_issue_mem5",     32'(mem[5]),          32'(old5));

        // Random traffic with occasional resets.
        rand_mode = 1;
        repeat (2000) tick();
        rand_mode = 0;
        rst = 1'b0;
        f_renew = 0; d_renew = 0;
        run_until_idle(50);
        for (int i = 0; i < 32; i++) chk("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
